mult_div_exec_unit: RTL

- Execution stage directly downstream of the multiply/divide reservation station.
- Takes one ready instruction at a time from the station head: operands, destination tag and RV32M funct3.
- Computes the result with a fixed-latency multiplier or an iterative restoring divider.
- Holds the result and tag on a request/grant port to the CDB arbiter until granted, then frees itself for the next instruction.

---
 rtl/mult_div_pkg.sv | 29 ++
 rtl/restoring_divider_core.sv | 73 +++++++
 rtl/mult_div_exec_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mult_div_pkg.sv
// Shared constants and types for the RV32M multiply/divide execution unit.
package mult_div_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_TAG_W  = 6;

  // RV32M funct3 encodings
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  // Divide special-case results
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDiv,
    StFix,
    StDone
  } state_e;

endpackage

// File: rtl/restoring_divider_core.sv
// Unsigned 32-bit restoring divider: one quotient bit per cycle, 32 cycles after start.
module restoring_divider_core (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        done_o
);

  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dsr_q, dsr_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        active_q, active_d;
  logic [32:0] rem_shift;
  logic [32:0] diff;

  // Shift-subtract step; quotient bits shift in where the dividend shifts out
  always_comb begin
    quo_d     = quo_q;
    rem_d     = rem_q;
    dsr_d     = dsr_q;
    cnt_d     = cnt_q;
    active_d  = active_q;
    rem_shift = {rem_q, quo_q[31]};
    diff      = rem_shift - {1'b0, dsr_q};
    if (start_i) begin
      quo_d    = dividend_i;
      rem_d    = '0;
      dsr_d    = divisor_i;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (!diff[32]) begin
        rem_d = diff[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = rem_shift[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 6'd1;
      if (cnt_q == 6'd31) begin
        active_d = 1'b0;
      end
    end
  end

  // Iteration state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      quo_q    <= '0;
      rem_q    <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dsr_q    <= dsr_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  // Pulses during the final iteration cycle; results are final on the next cycle
  assign done_o      = active_q & (cnt_q == 6'd31);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/mult_div_exec_unit.sv
// RV32M multiply/divide execution stage with a request/grant result port to the CDB.
module mult_div_exec_unit
  import mult_div_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TAG_W   = DEF_TAG_W,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issueque_ready,
  input  logic [DATA_W-1:0] issueque_rs1_data,
  input  logic [DATA_W-1:0] issueque_rs2_data,
  input  logic [TAG_W-1:0]  issueque_rd_tag,
  input  logic [2:0]        issueque_opcode,
  output logic              issueblk_done,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic [DATA_W-1:0] cdb_result_data,
  output logic [TAG_W-1:0]  cdb_result_tag,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [63:0]       prod_q, prod_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TAG_W-1:0]  res_tag_q, res_tag_d;

  logic        accept;
  logic        a_signed, b_signed;
  logic [63:0] a_ext, b_ext, prod_full;
  logic        div_signed, is_rem, div_zero, div_ovf;
  logic [31:0] a_mag, b_mag;
  logic        div_start, div_done;
  logic [31:0] div_quo, div_rem, q_fix, r_fix;

  // Reset gates the accept so the station never pops while the unit is held in reset
  assign accept        = issueque_ready & (state_q == StIdle) & reset;
  assign issueblk_done = accept;

  // Multiplier operands sign- or zero-extended per opcode; low 64 bits are exact either way
  assign a_signed  = (issueque_opcode == OP_MULH) | (issueque_opcode == OP_MULHSU);
  assign b_signed  = (issueque_opcode == OP_MULH);
  assign a_ext     = {{32{a_signed & issueque_rs1_data[31]}}, issueque_rs1_data};
  assign b_ext     = {{32{b_signed & issueque_rs2_data[31]}}, issueque_rs2_data};
  assign prod_full = a_ext * b_ext;

  // Divide operand classification at accept
  assign div_signed = ~issueque_opcode[0];
  assign is_rem     = issueque_opcode[1];
  assign div_zero   = (issueque_rs2_data == '0);
  assign div_ovf    = div_signed & (issueque_rs1_data == INT_MIN) & (&issueque_rs2_data);
  assign a_mag      = (div_signed & issueque_rs1_data[31]) ? -issueque_rs1_data
                                                           : issueque_rs1_data;
  assign b_mag      = (div_signed & issueque_rs2_data[31]) ? -issueque_rs2_data
                                                           : issueque_rs2_data;

  restoring_divider_core u_div (
    .clk_i       (clk),
    .rst_ni      (reset),
    .start_i     (div_start),
    .dividend_i  (a_mag),
    .divisor_i   (b_mag),
    .quotient_o  (div_quo),
    .remainder_o (div_rem),
    .done_o      (div_done)
  );

  assign q_fix = q_neg_q ? -div_quo : div_quo;
  assign r_fix = r_neg_q ? -div_rem : div_rem;

  // Next-state logic for the control FSM and registered CDB outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    tag_d     = tag_q;
    prod_d    = prod_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    req_d     = req_q;
    data_d    = data_q;
    res_tag_d = res_tag_q;
    div_start = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          op_d  = issueque_opcode;
          tag_d = issueque_rd_tag;
          cnt_d = '0;
          if (!issueque_opcode[2]) begin
            prod_d  = prod_full;
            state_d = StMul;
          end else if (div_zero || div_ovf) begin
            if (div_zero) begin
              data_d = is_rem ? issueque_rs1_data : DIV_ZERO_Q;
            end else begin
              data_d = is_rem ? '0 : INT_MIN;
            end
            res_tag_d = issueque_rd_tag;
            req_d     = 1'b1;
            state_d   = StDone;
          end else begin
            q_neg_d   = div_signed & (issueque_rs1_data[31] ^ issueque_rs2_data[31]);
            r_neg_d   = div_signed & issueque_rs1_data[31];
            div_start = 1'b1;
            state_d   = StDiv;
          end
        end
      end
      StMul: begin
        if (cnt_q == 4'(MUL_LAT - 1)) begin
          data_d    = (op_q == OP_MUL) ? prod_q[31:0] : prod_q[63:32];
          res_tag_d = tag_q;
          req_d     = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDiv: begin
        if (div_done) begin
          state_d = StFix;
        end
      end
      StFix: begin
        data_d    = op_q[1] ? r_fix : q_fix;
        res_tag_d = tag_q;
        req_d     = 1'b1;
        state_d   = StDone;
      end
      StDone: begin
        if (cdb_grant) begin
          req_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= '0;
      tag_q     <= '0;
      prod_q    <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      req_q     <= 1'b0;
      data_q    <= '0;
      res_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      prod_q    <= prod_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      req_q     <= req_d;
      data_q    <= data_d;
      res_tag_q <= res_tag_d;
    end
  end

  assign cdb_req         = req_q;
  assign cdb_result_data = data_q;
  assign cdb_result_tag  = res_tag_q;
  assign busy            = (state_q != StIdle);

endmodule
